// File: rtl/id_ex_pipeline_register.sv
// ID/EX boundary register with writeback bypass, load-use bubble insertion, EX hold and flush.
// Optional ID_EX_PERF_COUNT_EN adds bubble_count_o / hold_count_o event counters.
module id_ex_pipeline_register #(
    parameter int CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    input  logic              id_valid_i,
    input  logic [31:0]       id_pc_i,
    input  logic [31:0]       id_imm_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              id_mem_read_i,
    input  logic              id_reg_write_i,
    input  logic [31:0]       rf_op1_i,
    input  logic [31:0]       rf_op2_i,
    input  logic              wb_wr_en_i,
    input  logic [4:0]        wb_wr_addr_i,
    input  logic [31:0]       wb_wr_data_i,
    output logic              ex_valid_o,
    output logic [31:0]       ex_pc_o,
    output logic [31:0]       ex_imm_o,
    output logic [31:0]       ex_op1_o,
    output logic [31:0]       ex_op2_o,
    output logic [4:0]        ex_rs1_addr_o,
    output logic [4:0]        ex_rs2_addr_o,
    output logic [4:0]        ex_rd_addr_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_mem_read_o,
    output logic              ex_reg_write_o,
`ifdef ID_EX_PERF_COUNT_EN
    output logic [31:0]       bubble_count_o,
    output logic [31:0]       hold_count_o,
`endif
    output logic              load_use_stall_o
);

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       op1;
        logic [31:0]       op2;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              reg_write;
    } ex_stage_t;

    ex_stage_t ex_q, ex_d;
    logic [31:0] op1_byp, op2_byp;
    logic        stall;

    // The register file only shows a write on the following cycle, so forward it here.
    always_comb begin
        op1_byp = rf_op1_i;
        op2_byp = rf_op2_i;
        if (id_rs1_addr_i == 5'd0)
            op1_byp = 32'd0;
        else if (wb_wr_en_i && (wb_wr_addr_i == id_rs1_addr_i))
            op1_byp = wb_wr_data_i;
        if (id_rs2_addr_i == 5'd0)
            op2_byp = 32'd0;
        else if (wb_wr_en_i && (wb_wr_addr_i == id_rs2_addr_i))
            op2_byp = wb_wr_data_i;
    end

    assign stall = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) && id_valid_i &&
                   ((id_rs1_addr_i == ex_q.rd_addr) || (id_rs2_addr_i == ex_q.rd_addr));

    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (ex_hold_i) begin
            ex_d = ex_q;
        end else if (stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid_i;
            ex_d.pc        = id_pc_i;
            ex_d.imm       = id_imm_i;
            ex_d.op1       = op1_byp;
            ex_d.op2       = op2_byp;
            ex_d.rs1_addr  = id_rs1_addr_i;
            ex_d.rs2_addr  = id_rs2_addr_i;
            ex_d.rd_addr   = id_rd_addr_i;
            ex_d.ctrl      = id_ctrl_i;
            ex_d.mem_read  = id_mem_read_i && id_valid_i;
            ex_d.reg_write = id_reg_write_i && id_valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

`ifdef ID_EX_PERF_COUNT_EN
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] hold_count_q, hold_count_d;

    always_comb begin
        bubble_count_d = bubble_count_q;
        hold_count_d   = hold_count_q;
        if (flush_i || (!ex_hold_i && stall))
            bubble_count_d = bubble_count_q + 32'd1;
        if (!flush_i && ex_hold_i)
            hold_count_d = hold_count_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_count_q <= 32'd0;
            hold_count_q   <= 32'd0;
        end else begin
            bubble_count_q <= bubble_count_d;
            hold_count_q   <= hold_count_d;
        end
    end

    assign bubble_count_o = bubble_count_q;
    assign hold_count_o   = hold_count_q;
`endif

    assign ex_valid_o       = ex_q.valid;
    assign ex_pc_o          = ex_q.pc;
    assign ex_imm_o         = ex_q.imm;
    assign ex_op1_o         = ex_q.op1;
    assign ex_op2_o         = ex_q.op2;
    assign ex_rs1_addr_o    = ex_q.rs1_addr;
    assign ex_rs2_addr_o    = ex_q.rs2_addr;
    assign ex_rd_addr_o     = ex_q.rd_addr;
    assign ex_ctrl_o        = ex_q.ctrl;
    assign ex_mem_read_o    = ex_q.mem_read;
    assign ex_reg_write_o   = ex_q.reg_write;
    assign load_use_stall_o = stall;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register; counter checks compiled in with ID_EX_PERF_COUNT_EN.
module tb_id_ex_pipeline_register;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, ex_hold_i, id_valid_i;
    logic [31:0] id_pc_i, id_imm_i, rf_op1_i, rf_op2_i, wb_wr_data_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, wb_wr_addr_i;
    logic [15:0] id_ctrl_i;
    logic        id_mem_read_i, id_reg_write_i, wb_wr_en_i;
    logic        ex_valid_o, ex_mem_read_o, ex_reg_write_o, load_use_stall_o;
    logic [31:0] ex_pc_o, ex_imm_o, ex_op1_o, ex_op2_o;
    logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
    logic [15:0] ex_ctrl_o;
`ifdef ID_EX_PERF_COUNT_EN
    logic [31:0] bubble_count_o, hold_count_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    id_ex_pipeline_register #(.CTRL_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .ex_hold_i(ex_hold_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_ctrl_i(id_ctrl_i), .id_mem_read_i(id_mem_read_i), .id_reg_write_i(id_reg_write_i),
        .rf_op1_i(rf_op1_i), .rf_op2_i(rf_op2_i),
        .wb_wr_en_i(wb_wr_en_i), .wb_wr_addr_i(wb_wr_addr_i), .wb_wr_data_i(wb_wr_data_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
        .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_ctrl_o(ex_ctrl_o), .ex_mem_read_o(ex_mem_read_o), .ex_reg_write_o(ex_reg_write_o),
`ifdef ID_EX_PERF_COUNT_EN
        .bubble_count_o(bubble_count_o), .hold_count_o(hold_count_o),
`endif
        .load_use_stall_o(load_use_stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                          input logic rw, input logic [31:0] op1, input logic [31:0] op2);
        id_valid_i = v; id_pc_i = pc; id_imm_i = pc + 32'h4;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
        id_ctrl_i = {11'd0, rd}; id_mem_read_i = mr; id_reg_write_i = rw;
        rf_op1_i = op1; rf_op2_i = op2;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; ex_hold_i = 1'b0;
        wb_wr_en_i = 1'b0; wb_wr_addr_i = 5'd0; wb_wr_data_i = 32'd0;
        set_id(1'b1, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("reset_valid", ex_valid_o, 0);
        chk("reset_pc", ex_pc_o, 0);
        chk("reset_stall", load_use_stall_o, 0);
        rst_i = 1'b0;

        // add x3,x1,x2
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 32'd5, 32'd7);
        step();
        chk("add_op1", ex_op1_o, 5);
        chk("add_op2", ex_op2_o, 7);
        chk("add_rd", ex_rd_addr_o, 3);
        chk("add_valid", ex_valid_o, 1);
        chk("add_pc", ex_pc_o, 32'h100);
        chk("add_imm", ex_imm_o, 32'h104);
        chk("add_ctrl", ex_ctrl_o, 16'h3);
        chk("add_rw", ex_reg_write_o, 1);

        // WB bypass on rs1, x0 never bypassed, bypass on rs2, no bypass without wr_en
        set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1, 32'h1, 32'd7);
        wb_wr_en_i = 1'b1; wb_wr_addr_i = 5'd1; wb_wr_data_i = 32'hDEAD;
        step();
        chk("byp_op1", ex_op1_o, 32'hDEAD);
        chk("byp_op2_untouched", ex_op2_o, 7);
        set_id(1'b1, 32'h108, 5'd0, 5'd2, 5'd4, 1'b0, 1'b1, 32'h99, 32'd7);
        wb_wr_addr_i = 5'd0; wb_wr_data_i = 32'h55;
        step();
        chk("x0_op1", ex_op1_o, 0);
        set_id(1'b1, 32'h10C, 5'd3, 5'd9, 5'd4, 1'b0, 1'b1, 32'h33, 32'h44);
        wb_wr_addr_i = 5'd9; wb_wr_data_i = 32'h1234;
        step();
        chk("byp_op2", ex_op2_o, 32'h1234);
        chk("byp_op1_rf", ex_op1_o, 32'h33);
        wb_wr_en_i = 1'b0;
        step();
        chk("nowb_op2", ex_op2_o, 32'h44);

        // lw x5 then add x6,x5,x7: one bubble
        set_id(1'b1, 32'h200, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 32'h8, 32'h0);
        step();
        chk("lw_mr", ex_mem_read_o, 1);
        chk("lw_rd", ex_rd_addr_o, 5);
        set_id(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1, 32'h1, 32'h2);
        #1;
        chk("lu_stall_rs1", load_use_stall_o, 1);
        step();
        chk("lu_bubble_valid", ex_valid_o, 0);
        chk("lu_bubble_mr", ex_mem_read_o, 0);
        chk("lu_bubble_rw", ex_reg_write_o, 0);
        chk("lu_bubble_rd", ex_rd_addr_o, 0);
        chk("lu_stall_cleared", load_use_stall_o, 0);
        step();
        chk("lu_cap_valid", ex_valid_o, 1);
        chk("lu_cap_rd", ex_rd_addr_o, 6);
        chk("lu_cap_rs1", ex_rs1_addr_o, 5);

        // lw x8 then consumer via rs2; idle ID must not stall
        set_id(1'b1, 32'h208, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        set_id(1'b1, 32'h20C, 5'd1, 5'd8, 5'd9, 1'b0, 1'b1, 32'h1, 32'h2);
        #1;
        chk("lu_stall_rs2", load_use_stall_o, 1);
        id_valid_i = 1'b0;
        #1;
        chk("lu_no_stall_idle", load_use_stall_o, 0);
        id_valid_i = 1'b1;
        step();
        chk("lu2_bubble", ex_valid_o, 0);
        step();
        chk("lu2_cap_rd", ex_rd_addr_o, 9);

        // hold for 3 cycles, then flush together with hold
        set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd10, 1'b0, 1'b1, 32'hA, 32'hB);
        step();
        chk("pre_hold_pc", ex_pc_o, 32'h300);
        ex_hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'h400 + i, 5'd3, 5'd4, 5'd11, 1'b0, 1'b1, 32'h77, 32'h88);
            step();
            chk("hold_pc", ex_pc_o, 32'h300);
            chk("hold_op1", ex_op1_o, 32'hA);
            chk("hold_rd", ex_rd_addr_o, 10);
        end
        flush_i = 1'b1;
        step();
        chk("flush_hold_valid", ex_valid_o, 0);
        chk("flush_hold_pc", ex_pc_o, 0);
        flush_i = 1'b0; ex_hold_i = 1'b0;
        step();
        chk("post_flush_pc", ex_pc_o, 32'h402);
        chk("post_flush_valid", ex_valid_o, 1);
`ifdef ID_EX_PERF_COUNT_EN
        chk("bubble_count", bubble_count_o, 3);
        chk("hold_count", hold_count_o, 3);
`endif

        // asynchronous reset between edges
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", ex_valid_o, 0);
        chk("async_rst_pc", ex_pc_o, 0);
        chk("async_rst_op1", ex_op1_o, 0);
        chk("async_rst_rw", ex_reg_write_o, 0);
`ifdef ID_EX_PERF_COUNT_EN
        chk("async_rst_bubbles", bubble_count_o, 0);
`endif
        step();
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
